br_fifo_shared_pop_wrr_arbiter: RTL and testbench

Weighted round-robin arbiter that drives the external arbiter interface of the shared multi-FIFO pop controller with credit-based flow control. It makes one independent grant decision per read port each cycle. It never grants the same logical FIFO on two read ports in the same cycle. Each FIFO holds priority on a port for a configurable burst of grants before priority rotates.

---
 rtl/br_fifo_shared_pop_wrr_arbiter.sv | 139 +++++++++++++
 tb/tb_br_fifo_shared_pop_wrr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/br_fifo_shared_pop_wrr_arbiter.sv
// Weighted round-robin grant per read port with chaining; BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN builds burst weights.
// Latency: grant/can_grant are combinational; ptr/used update on the clk edge after an enabled grant.
// Backpressure: no grant is made or committed while rst is high; state moves only when enable_priority_update is set.
module br_fifo_shared_pop_wrr_arbiter #(
    parameter int NumReadPorts = 1,
    parameter int NumFifos = 2,
    parameter int MaxWeight = 4,
    localparam int FifoIdWidth = (NumFifos > 1) ? $clog2(NumFifos) : 1,
    localparam int WeightWidth = $clog2(MaxWeight + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumFifos-1:0][WeightWidth-1:0]    weight,
    input  logic [NumReadPorts-1:0][NumFifos-1:0]   request,
    output logic [NumReadPorts-1:0][NumFifos-1:0]   grant,
    output logic [NumReadPorts-1:0][NumFifos-1:0]   can_grant,
    input  logic [NumReadPorts-1:0]                 enable_priority_update
);

    // Position of idx in the search order that starts at base.
    function automatic int search_dist(input int idx, input int base);
        return (idx >= base) ? (idx - base) : (idx + NumFifos - base);
    endfunction

    logic [NumReadPorts-1:0][FifoIdWidth-1:0] ptr;
    logic [NumReadPorts-1:0][FifoIdWidth-1:0] ptr_nxt;
    logic [NumReadPorts-1:0][NumFifos-1:0]    grant_int;
    logic [NumReadPorts-1:0][NumFifos-1:0]    can_int;
    logic [NumFifos-1:0]                      taken;
    logic [NumFifos-1:0]                      eff_req;
    logic                                     blk_req;
    logic                                     blk_free;
    logic [FifoIdWidth-1:0]                   g_idx;
    logic [FifoIdWidth-1:0]                   g_inc;

    // Ports are resolved in order; a FIFO granted on a lower port is invisible to higher ones.
    always_comb begin
        taken     = '0;
        eff_req   = '0;
        blk_req   = 1'b0;
        blk_free  = 1'b0;
        grant_int = '0;
        can_int   = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            eff_req = request[p] & ~taken;
            for (int f = 0; f < NumFifos; f++) begin
                blk_req  = 1'b0;
                blk_free = 1'b0;
                for (int j = 0; j < NumFifos; j++) begin
                    if (search_dist(j, int'(ptr[p])) < search_dist(f, int'(ptr[p]))) begin
                        if (eff_req[j]) blk_req = 1'b1;
                        if (!taken[j]) blk_free = 1'b1;
                    end
                end
                // With nothing requesting, only the first free FIFO in search order is offered.
                can_int[p][f] = !taken[f] && !((eff_req != '0) ? blk_req : blk_free);
            end
            grant_int[p] = can_int[p] & eff_req;
            taken        = taken | grant_int[p];
        end
    end

    assign grant     = rst ? '0 : grant_int;
    assign can_grant = rst ? '0 : can_int;

`ifdef BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN
    logic [NumReadPorts-1:0][WeightWidth-1:0] used;
    logic [NumReadPorts-1:0][WeightWidth-1:0] used_nxt;
    logic [NumFifos-1:0][WeightWidth-1:0]     w_eff;
    logic [WeightWidth-1:0]                   g_weight;
    logic [WeightWidth:0]                     used_inc;

    always_comb begin
        w_eff = '0;
        for (int f = 0; f < NumFifos; f++) begin
            w_eff[f] = (weight[f] == '0) ? WeightWidth'(1) : weight[f];
        end
    end
`else
    logic unused_weight;
    assign unused_weight = ^weight;
`endif

    always_comb begin
        ptr_nxt = ptr;
        g_idx   = '0;
        g_inc   = '0;
`ifdef BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN
        used_nxt = used;
        g_weight = '0;
        used_inc = '0;
`endif
        for (int p = 0; p < NumReadPorts; p++) begin
            g_idx = '0;
            for (int f = 0; f < NumFifos; f++) begin
                if (grant_int[p][f]) g_idx = FifoIdWidth'(f);
            end
            g_inc = (int'(g_idx) == NumFifos - 1) ? '0 : g_idx + 1'b1;
            if (enable_priority_update[p] && (grant_int[p] != '0)) begin
`ifdef BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN
                g_weight = w_eff[g_idx];
                used_inc = {1'b0, used[p]} + 1'b1;
                if (g_idx == ptr[p]) begin
                    // A shrunken weight can leave used at or above it; that rotates here.
                    if (used_inc < {1'b0, g_weight}) begin
                        used_nxt[p] = used_inc[WeightWidth-1:0];
                    end else begin
                        ptr_nxt[p]  = g_inc;
                        used_nxt[p] = '0;
                    end
                end else if (g_weight > WeightWidth'(1)) begin
                    ptr_nxt[p]  = g_idx;
                    used_nxt[p] = WeightWidth'(1);
                end else begin
                    ptr_nxt[p]  = g_inc;
                    used_nxt[p] = '0;
                end
`else
                ptr_nxt[p] = g_inc;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
`ifdef BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN
            used <= '0;
`endif
        end else begin
            ptr <= ptr_nxt;
`ifdef BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN
            used <= used_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_br_fifo_shared_pop_wrr_arbiter.sv
// Directed bench: 2-port/4-FIFO instance plus a 1-port/3-FIFO instance for non-power-of-2 wrap.
module tb_br_fifo_shared_pop_wrr_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic [3:0][2:0] w4;
    logic [1:0][3:0] req4;
    logic [1:0][3:0] gnt4;
    logic [1:0][3:0] can4;
    logic [1:0]      en4;

    logic [2:0][2:0] w3;
    logic [0:0][2:0] req3;
    logic [0:0][2:0] gnt3;
    logic [0:0][2:0] can3;
    logic [0:0]      en3;

    int n_chk = 0;
    int n_bad = 0;

    int wrr_seq [8];
    int mb_seq  [4];

    br_fifo_shared_pop_wrr_arbiter #(
        .NumReadPorts(2), .NumFifos(4), .MaxWeight(4)
    ) u_dut4 (
        .clk(clk), .rst(rst), .weight(w4), .request(req4),
        .grant(gnt4), .can_grant(can4), .enable_priority_update(en4)
    );

    br_fifo_shared_pop_wrr_arbiter #(
        .NumReadPorts(1), .NumFifos(3), .MaxWeight(4)
    ) u_dut3 (
        .clk(clk), .rst(rst), .weight(w3), .request(req3),
        .grant(gnt3), .can_grant(can3), .enable_priority_update(en3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef BR_FIFO_SHARED_POP_WRR_ARB_WEIGHTS_EN
        wrr_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
        mb_seq  = '{2, 2, 2, 0};
`else
        wrr_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
        mb_seq  = '{0, 2, 0, 2};
`endif
        rst  = 1'b1;
        w4   = {3'd1, 3'd1, 3'd1, 3'd1};
        w3   = {3'd1, 3'd1, 3'd1};
        req4 = '0;
        req3 = '0;
        en3  = '0;
        req4[0] = 4'b1111;
        en4     = 2'b11;

        // Outputs forced low during reset; enable is ignored.
        #1;
        chk("rst_gnt0", 32'(gnt4[0]), 0);
        chk("rst_can0", 32'(can4[0]), 0);
        chk("rst_can1", 32'(can4[1]), 0);
        cycle();
        cycle();
        rst = 1'b0;
        en4 = 2'b01;

        // Unit weights: plain rotation 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_gnt0", 32'(gnt4[0]), 1 << (i % 4));
            chk("rr_can1", 32'(can4[1]), ((i % 4) == 0) ? 2 : 1);
            cycle();
        end
        req4[0] = 4'b0000;
        en4     = 2'b00;
        #1;
        chk("noreq_can0", 32'(can4[0]), 2);

        // Updates disabled: priority stays at FIFO 0.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req4[0] = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_gnt0", 32'(gnt4[0]), 1);
            cycle();
        end
        req4[0] = 4'b0000;
        #1;
        chk("hold_ptr0", 32'(can4[0]), 1);

        // Weighted bursts: weight[0]=3, weight[1]=1.
        w4[0]   = 3'd3;
        req4[0] = 4'b0011;
        en4     = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("wrr_gnt0", 32'(gnt4[0]), 1 << wrr_seq[i]);
            cycle();
        end

        // Zero weight behaves as one: ptr 2 -> 3 after a single grant.
        w4      = {3'd1, 3'd0, 3'd1, 3'd1};
        req4[0] = 4'b0100;
        #1;
        chk("w0_gnt0", 32'(gnt4[0]), 4);
        cycle();
        req4[0] = 4'b0000;
        en4     = 2'b00;
        #1;
        chk("w0_ptr0", 32'(can4[0]), 8);

        // Two ports with identical requests never share a FIFO.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        w4      = {3'd1, 3'd1, 3'd1, 3'd1};
        req4[0] = 4'b0110;
        req4[1] = 4'b0110;
        #1;
        chk("dual_gnt0", 32'(gnt4[0]), 2);
        chk("dual_gnt1", 32'(gnt4[1]), 4);
        chk("dual_can0", 32'(can4[0]), 3);
        chk("dual_can1", 32'(can4[1]), 5);
        en4 = 2'b10;
        cycle();
        en4  = 2'b00;
        req4 = '0;
        #1;
        chk("dual_ptr1", 32'(can4[1]), 8);
        chk("dual_ptr0", 32'(can4[0]), 1);

        // Reset in the middle of a weight-4 burst on FIFO 2.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        w4[2]   = 3'd4;
        req4[0] = 4'b0100;
        en4     = 2'b01;
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        chk("mb_rst_gnt0", 32'(gnt4[0]), 0);
        chk("mb_rst_can0", 32'(can4[0]), 0);
        cycle();
        rst = 1'b0;
        #1;
        chk("mb_gnt0", 32'(gnt4[0]), 4);
        chk("mb_can0", 32'(can4[0]), 7);
        cycle();
        req4[0] = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mb_seq_gnt0", 32'(gnt4[0]), 1 << mb_seq[i]);
            cycle();
        end

        // Three FIFOs: wrap from ptr 2 back to 0.
        req4 = '0;
        en4  = 2'b00;
        rst  = 1'b1;
        cycle();
        rst = 1'b0;
        req3[0] = 3'b010;
        en3     = 1'b1;
        cycle();
        req3[0] = 3'b101;
        #1;
        chk("wrap_gnt_a", 32'(gnt3[0]), 4);
        cycle();
        #1;
        chk("wrap_gnt_b", 32'(gnt3[0]), 1);
        chk("wrap_can_b", 32'(can3[0]), 1);
        cycle();
        req3[0] = 3'b000;
        en3     = 1'b0;
        #1;
        chk("wrap_ptr", 32'(can3[0]), 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
